// File: rtl/system_crossbar_rr.sv
// system_crossbar_rr: registered master/slave crossbar. Each slave has its own
// IDLE/BUSY/RESP FSM with two-class round-robin arbitration. Misses in the
// address map get a decode-error response, and stalled slaves get a timeout.
module system_crossbar_rr #(
  parameter int NUM_MASTERS    = 9,
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000},
  parameter logic [NUM_MASTERS-1:0] HI_PRIO_MASK = 9'h1FE,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_err,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_SLAVES-1:0]            s_req,
  output logic [NUM_SLAVES-1:0]            s_we,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_addr,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wdata,
  output logic [NUM_SLAVES*ID_WIDTH-1:0]   s_id,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MST_LAST = MW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t                           r_state [NUM_SLAVES];
  logic [MW-1:0]                    r_ptr   [NUM_SLAVES];
  logic [MW-1:0]                    r_win   [NUM_SLAVES];
  logic [CW-1:0]                    r_cnt   [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]            r_s_req, r_s_we;
  logic [NUM_SLAVES*ADDR_WIDTH-1:0] r_s_addr;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] r_s_wdata;
  logic [NUM_SLAVES*ID_WIDTH-1:0]   r_s_id;
  logic [NUM_MASTERS-1:0]           r_m_ack, r_m_err, r_dack, r_cool;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] r_m_rdata;

  logic [NUM_MASTERS-1:0]           w_hit;
  logic [SW-1:0]                    w_sel   [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]           w_reqv  [NUM_SLAVES];
  logic [NUM_MASTERS-1:0]           w_elig  [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]            w_gnt, w_done, w_tmo;
  logic [MW-1:0]                    w_gidx  [NUM_SLAVES];
  logic [NUM_MASTERS-1:0]           w_derr, w_ack_nxt, w_err_nxt;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] w_rdata_nxt;

  assign s_req   = r_s_req;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_id    = r_s_id;
  assign m_ack   = r_m_ack;
  assign m_err   = r_m_err;
  assign m_rdata = r_m_rdata;

  // Address decode: scan from the top so the lowest matching slave wins.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_hit[m] = 1'b0;
      w_sel[m] = '0;
      for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
        if ((m_addr[m*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH])
            == SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
          w_hit[m] = 1'b1;
          w_sel[m] = SW'(s);
        end
      end
    end
  end

  // Per-slave arbitration: the high class shadows the low class, then round-robin from ptr.
  always_comb begin
    int v_idx;
    v_idx = 0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_reqv[s] = '0;
      w_gnt[s]  = 1'b0;
      w_gidx[s] = '0;
      for (int m = 0; m < NUM_MASTERS; m++)
        w_reqv[s][m] = m_req[m] & w_hit[m] & (w_sel[m] == SW'(s));
      w_elig[s] = (|(w_reqv[s] & HI_PRIO_MASK)) ? (w_reqv[s] & HI_PRIO_MASK)
                                                 : (w_reqv[s] & ~HI_PRIO_MASK);
      for (int k = 0; k < NUM_MASTERS; k++) begin
        v_idx = int'(r_ptr[s]) + k;
        if (v_idx >= NUM_MASTERS) v_idx = v_idx - NUM_MASTERS;
        if (!w_gnt[s] && w_elig[s][v_idx]) begin
          w_gnt[s]  = 1'b1;
          w_gidx[s] = MW'(v_idx);
        end
      end
    end
  end

  // Next master response: at most one source per master (one slave or the decode-error path).
  always_comb begin
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_rdata_nxt = '0;
    w_done      = '0;
    w_tmo       = '0;
    w_derr      = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_done[s] = (r_state[s] == ST_BUSY) && s_ack[s];
      w_tmo[s]  = (r_state[s] == ST_BUSY) && !s_ack[s] && (r_cnt[s] == CNT_LAST);
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if ((w_done[s] || w_tmo[s]) && (r_win[s] == MW'(m))) begin
          w_ack_nxt[m] = 1'b1;
          w_err_nxt[m] = w_tmo[s];
          if (w_done[s])
            w_rdata_nxt[m*DATA_WIDTH +: DATA_WIDTH] = s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_derr[m] = m_req[m] & ~w_hit[m] & ~r_dack[m] & ~r_cool[m];
      if (w_derr[m]) begin
        w_ack_nxt[m] = 1'b1;
        w_err_nxt[m] = 1'b1;
      end
    end
  end

  // Per-slave FSM: grant and latch the payload, hold it while busy, then one response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        r_state[s] <= ST_IDLE;
        r_ptr[s]   <= '0;
        r_win[s]   <= '0;
        r_cnt[s]   <= '0;
      end
      r_s_req   <= '0;
      r_s_we    <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_id    <= '0;
    end else begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        case (r_state[s])
          ST_IDLE: begin
            if (w_gnt[s]) begin
              r_s_req[s]                             <= 1'b1;
              r_s_we[s]                              <= m_we[w_gidx[s]];
              r_s_addr[s*ADDR_WIDTH +: ADDR_WIDTH]   <= m_addr[w_gidx[s]*ADDR_WIDTH +: ADDR_WIDTH];
              r_s_wdata[s*DATA_WIDTH +: DATA_WIDTH]  <= m_wdata[w_gidx[s]*DATA_WIDTH +: DATA_WIDTH];
              r_s_id[s*ID_WIDTH +: ID_WIDTH]         <= m_id[w_gidx[s]*ID_WIDTH +: ID_WIDTH];
              r_win[s]   <= w_gidx[s];
              r_ptr[s]   <= (w_gidx[s] == MST_LAST) ? '0 : w_gidx[s] + 1'b1;
              r_cnt[s]   <= '0;
              r_state[s] <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (w_done[s] || w_tmo[s]) begin
              r_s_req[s] <= 1'b0;
              r_state[s] <= ST_RESP;
            end else begin
              r_cnt[s] <= r_cnt[s] + 1'b1;
            end
          end
          ST_RESP: r_state[s] <= ST_IDLE;
          default: r_state[s] <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered master responses; decode errors get one blocking cycle and one cooldown cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_ack   <= '0;
      r_m_err   <= '0;
      r_m_rdata <= '0;
      r_dack    <= '0;
      r_cool    <= '0;
    end else begin
      r_m_ack   <= w_ack_nxt;
      r_m_err   <= w_err_nxt;
      r_m_rdata <= w_rdata_nxt;
      r_dack    <= w_derr;
      r_cool    <= r_dack;
    end
  end

endmodule

// File: tb/tb_system_crossbar_rr.sv
// Directed bench for system_crossbar_rr: master agents drop a request the cycle
// after its ack and optionally re-request; slaves ack combinationally when enabled.
module tb_system_crossbar_rr;
  localparam int NM = 9, NS = 4, AW = 32, DW = 32, IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0] m_req, m_we, m_ack, m_err;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NM*IW-1:0] m_id;
  logic [NS-1:0] s_req, s_we, s_ack;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_wdata, s_rdata;
  logic [NS*IW-1:0] s_id;

  logic [NS-1:0]    ack_en;
  logic [NS*DW-1:0] slv_rd;
  assign s_ack   = s_req & ack_en;
  assign s_rdata = slv_rd;

  int n_pass = 0, n_total = 0, cyc = 0;
  logic [NM-1:0] raise_next, drop_next;
  int rem [NM];
  int ack_cnt [NM];
  int q_mst [$];
  logic q_err [$];
  logic [DW-1:0] q_rd [$];
  logic [NS-1:0] sreq_seen;

  system_crossbar_rr #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_id(m_id),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_id(s_id),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, required the bench to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One cycle of the master agents, applied and observed at the falling edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int m = 0; m < NM; m++) begin
      if (raise_next[m]) begin
        m_req[m] = 1'b1; raise_next[m] = 1'b0;
      end else if (drop_next[m]) begin
        m_req[m] = 1'b0; drop_next[m] = 1'b0;
        if (rem[m] > 0) raise_next[m] = 1'b1;
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (m_ack[m] === 1'b1) begin
        ack_cnt[m]++;
        q_mst.push_back(m);
        q_err.push_back(m_err[m]);
        q_rd.push_back(m_rdata[m*DW +: DW]);
        if (rem[m] > 0) rem[m]--;
        drop_next[m] = 1'b1;
      end
    end
    sreq_seen = sreq_seen | s_req;
  endtask

  task automatic clear_tb();
    m_req = '0; raise_next = '0; drop_next = '0; sreq_seen = '0;
    for (int m = 0; m < NM; m++) begin rem[m] = 0; ack_cnt[m] = 0; end
    q_mst.delete(); q_err.delete(); q_rd.delete();
  endtask

  task automatic set_master(input int m, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [IW-1:0] id);
    m_we[m] = we;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = wd;
    m_id[m*IW +: IW] = id;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_we = '0; m_addr = '0; m_wdata = '0; m_id = '0;
    ack_en = '0; slv_rd = '0;
    clear_tb();
    @(negedge clk); @(negedge clk);
    n_total++; if (s_req !== 4'b0) $display("FAIL rst_sreq: got %b expected 0", s_req); else n_pass++;
    n_total++; if (m_ack !== 9'b0 || m_err !== 9'b0) $display("FAIL rst_ack: got %b/%b expected 0", m_ack, m_err); else n_pass++;
    n_total++; if (m_rdata !== '0 || s_addr !== '0 || s_we !== '0) $display("FAIL rst_data: rdata %h s_addr %h expected 0", m_rdata, s_addr); else n_pass++;
    rst = 1'b0;
    idle(3);
    n_total++; if (s_req !== 4'b0 || m_ack !== 9'b0) $display("FAIL rst_quiet: s_req %b m_ack %b expected 0", s_req, m_ack); else n_pass++;
  endtask

  task automatic test_single_read();
    clear_tb();
    set_master(0, 1'b0, 32'h0000_0040, 32'h0, 4'h5);
    slv_rd[0*DW +: DW] = 32'h1234_5678;
    ack_en = 4'b1111;
    rem[0] = 1; raise_next[0] = 1'b1;
    cycle();
    cycle();
    n_total++; if (s_req !== 4'b0001) $display("FAIL rd_sreq_c1: got %b expected 0001", s_req); else n_pass++;
    n_total++; if (s_addr[0 +: AW] !== 32'h0000_0040 || s_id[0 +: IW] !== 4'h5) $display("FAIL rd_payload: addr %h id %h expected 00000040/5", s_addr[0 +: AW], s_id[0 +: IW]); else n_pass++;
    n_total++; if (m_ack !== 9'b0) $display("FAIL rd_noack_c1: got %b expected 0", m_ack); else n_pass++;
    cycle();
    n_total++; if (m_ack !== 9'b0_0000_0001 || m_err !== 9'b0) $display("FAIL rd_ack_c2: ack %b err %b expected 000000001/0", m_ack, m_err); else n_pass++;
    n_total++; if (m_rdata[0 +: DW] !== 32'h1234_5678) $display("FAIL rd_data: got %h expected 12345678", m_rdata[0 +: DW]); else n_pass++;
    idle(4);
    n_total++; if (ack_cnt[0] !== 1 || s_req !== 4'b0) $display("FAIL rd_once: acks %0d s_req %b expected 1/0000", ack_cnt[0], s_req); else n_pass++;
  endtask

  task automatic test_priority_rr();
    int exp_order [5];
    exp_order = '{3, 5, 3, 5, 0};
    clear_tb();
    set_master(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    set_master(3, 1'b0, 32'h0000_0204, 32'h0, 4'h3);
    set_master(5, 1'b0, 32'h0000_0208, 32'h0, 4'h5);
    slv_rd[0*DW +: DW] = 32'h5555_0000;
    rem[0] = 1; rem[3] = 2; rem[5] = 2;
    raise_next[0] = 1'b1; raise_next[3] = 1'b1; raise_next[5] = 1'b1;
    for (int i = 0; i < 60 && q_mst.size() < 5; i++) cycle();
    n_total++; if (q_mst.size() != 5) $display("FAIL rr_count: got %0d acks expected 5", q_mst.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (i >= q_mst.size() || q_mst[i] != exp_order[i])
        $display("FAIL rr_order%0d: got %0d expected %0d", i, (i < q_mst.size()) ? q_mst[i] : -1, exp_order[i]);
      else n_pass++;
    end
    idle(4);
    n_total++; if (ack_cnt[0] !== 1 || ack_cnt[3] !== 2 || ack_cnt[5] !== 2) $display("FAIL rr_totals: %0d/%0d/%0d expected 1/2/2", ack_cnt[0], ack_cnt[3], ack_cnt[5]); else n_pass++;
  endtask

  task automatic test_decode_error();
    clear_tb();
    set_master(2, 1'b0, 32'h4000_0000, 32'h0, 4'h2);
    rem[2] = 1; raise_next[2] = 1'b1;
    cycle();
    cycle();
    n_total++; if (m_ack !== 9'b0_0000_0100 || m_err[2] !== 1'b1) $display("FAIL dec_ack: ack %b err %b expected 000000100/1", m_ack, m_err); else n_pass++;
    n_total++; if (m_rdata[2*DW +: DW] !== 32'h0) $display("FAIL dec_rdata: got %h expected 0", m_rdata[2*DW +: DW]); else n_pass++;
    idle(6);
    n_total++; if (ack_cnt[2] !== 1) $display("FAIL dec_once: got %0d acks expected 1", ack_cnt[2]); else n_pass++;
    n_total++; if (sreq_seen !== 4'b0) $display("FAIL dec_nosreq: got %b expected 0000", sreq_seen); else n_pass++;
  endtask

  task automatic test_timeout();
    int hi_cnt;
    clear_tb();
    set_master(1, 1'b0, 32'h1000_0010, 32'h0, 4'h1);
    set_master(6, 1'b1, 32'h1000_0020, 32'h6666_6666, 4'h6);
    slv_rd[1*DW +: DW] = 32'hBAD0_0001;
    ack_en[1] = 1'b0;
    rem[1] = 1; rem[6] = 1; raise_next[1] = 1'b1; raise_next[6] = 1'b1;
    cycle();
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_req[1] === 1'b1) hi_cnt++;
    end
    n_total++; if (hi_cnt != 8 || s_addr[AW +: AW] !== 32'h1000_0010) $display("FAIL to_busy: s_req high %0d cycles addr %h expected 8/10000010", hi_cnt, s_addr[AW +: AW]); else n_pass++;
    cycle();
    n_total++; if (s_req[1] !== 1'b0) $display("FAIL to_drop: got %b expected 0", s_req[1]); else n_pass++;
    n_total++; if (m_ack !== 9'b0_0000_0010 || m_err[1] !== 1'b1 || m_rdata[DW +: DW] !== 32'h0) $display("FAIL to_resp: ack %b err %b rdata %h expected 000000010/1/0", m_ack, m_err, m_rdata[DW +: DW]); else n_pass++;
    for (int i = 0; i < 6 && s_req[1] !== 1'b1; i++) cycle();
    n_total++; if (s_req[1] !== 1'b1 || s_addr[AW +: AW] !== 32'h1000_0020 || s_we[1] !== 1'b1 || s_wdata[DW +: DW] !== 32'h6666_6666) $display("FAIL to_next: s_req %b addr %h we %b wdata %h expected 1/10000020/1/66666666", s_req[1], s_addr[AW +: AW], s_we[1], s_wdata[DW +: DW]); else n_pass++;
    ack_en[1] = 1'b1;
    for (int i = 0; i < 6 && ack_cnt[6] == 0; i++) cycle();
    n_total++; if (q_mst.size() != 2 || q_mst[1] != 6 || q_err[1] !== 1'b0 || q_rd[1] !== 32'hBAD0_0001) $display("FAIL to_m6: %0d acks, expected a clean ack to master 6 with BAD00001", q_mst.size()); else n_pass++;
    idle(3);
  endtask

  task automatic test_concurrency();
    clear_tb();
    set_master(1, 1'b0, 32'h0000_0080, 32'h0, 4'h1);
    set_master(4, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'h9);
    slv_rd[0*DW +: DW] = 32'hA0A0_A0A0;
    slv_rd[2*DW +: DW] = 32'hB0B0_B0B0;
    ack_en = 4'b1111;
    rem[1] = 1; rem[4] = 1; raise_next[1] = 1'b1; raise_next[4] = 1'b1;
    cycle();
    cycle();
    n_total++; if (s_req !== 4'b0101) $display("FAIL cc_sreq: got %b expected 0101", s_req); else n_pass++;
    n_total++; if (s_we[2] !== 1'b1 || s_wdata[2*DW +: DW] !== 32'hDEAD_BEEF || s_id[2*IW +: IW] !== 4'h9) $display("FAIL cc_write: we %b wdata %h id %h expected 1/DEADBEEF/9", s_we[2], s_wdata[2*DW +: DW], s_id[2*IW +: IW]); else n_pass++;
    cycle();
    n_total++; if (m_ack !== 9'b0_0001_0010 || m_err !== 9'b0) $display("FAIL cc_ack: ack %b err %b expected 000010010/0", m_ack, m_err); else n_pass++;
    n_total++; if (m_rdata[1*DW +: DW] !== 32'hA0A0_A0A0 || m_rdata[4*DW +: DW] !== 32'hB0B0_B0B0) $display("FAIL cc_rdata: got %h/%h expected A0A0A0A0/B0B0B0B0", m_rdata[1*DW +: DW], m_rdata[4*DW +: DW]); else n_pass++;
    idle(4);
  endtask

  task automatic test_reset_mid_busy();
    clear_tb();
    set_master(7, 1'b0, 32'h0000_0300, 32'h0, 4'h7);
    set_master(2, 1'b0, 32'h4000_0000, 32'h0, 4'h2);
    ack_en = 4'b0000;
    rem[7] = 1; rem[2] = 1; raise_next[7] = 1'b1; raise_next[2] = 1'b1;
    cycle();
    cycle();
    n_total++; if (s_req[0] !== 1'b1 || m_ack[2] !== 1'b1) $display("FAIL rb_pre: s_req %b m_ack %b expected busy slave 0 and ack 2", s_req, m_ack); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (s_req !== 4'b0 || m_ack !== 9'b0 || m_err !== 9'b0) $display("FAIL rb_async: s_req %b m_ack %b m_err %b expected 0", s_req, m_ack, m_err); else n_pass++;
    clear_tb();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    set_master(3, 1'b0, 32'h0000_0400, 32'h0, 4'h3);
    set_master(8, 1'b0, 32'h0000_0800, 32'h0, 4'h8);
    slv_rd[0*DW +: DW] = 32'h0F0F_0F0F;
    ack_en = 4'b1111;
    rem[3] = 1; rem[8] = 1; raise_next[3] = 1'b1; raise_next[8] = 1'b1;
    cycle();
    cycle();
    n_total++; if (s_req !== 4'b0001 || s_addr[0 +: AW] !== 32'h0000_0400) $display("FAIL rb_ptr: s_req %b addr %h expected 0001/00000400", s_req, s_addr[0 +: AW]); else n_pass++;
    cycle();
    n_total++; if (m_ack !== 9'b0_0000_1000 || m_rdata[3*DW +: DW] !== 32'h0F0F_0F0F) $display("FAIL rb_ack: ack %b rdata %h expected 000001000/0F0F0F0F", m_ack, m_rdata[3*DW +: DW]); else n_pass++;
    for (int i = 0; i < 20 && q_mst.size() < 2; i++) cycle();
    n_total++; if (q_mst.size() != 2 || q_mst[1] != 8) $display("FAIL rb_next: %0d acks, expected a second ack to master 8", q_mst.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority_rr();
    test_decode_error();
    test_timeout();
    test_concurrency();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
